dmem_responder: RTL and testbench

Data-side memory responder for the single-cycle `cpu`. It answers the core's `daddr`/`dwdata`/`dwe` requests with `drdata` in the same cycle, using a byte-lane-writable data RAM. It also provides a small memory-mapped I/O window with an LED output register, a free-running cycle counter, a store counter and a sticky access-error flag. It sits between `cpu` and the board-level top.

---
 rtl/dmem_pkg.sv | 13 +
 rtl/dmem_ram.sv | 16 +
 rtl/dmem_responder.sv | 74 +++++++
 tb/tb_dmem_responder.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared MMIO offsets, default window base, decode kinds and lane-merge helper.
package dmem_pkg;
  localparam logic [31:0] MMIO_BASE_DEF = 32'hFFFF_FF00;
  localparam logic [7:0] OFF_LED = 8'h00;
  localparam logic [7:0] OFF_CYCLE = 8'h04;
  localparam logic [7:0] OFF_STORES = 8'h08;
  localparam logic [7:0] OFF_STATUS = 8'h0C;
  typedef enum logic [1:0] {K_RAM, K_MMIO, K_OOR} kind_e;
  function automatic logic [31:0] lane_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                             input logic [3:0] be);
    for (int i = 0; i < 4; i++) lane_merge[8*i+:8] = be[i] ? new_v[8*i+:8] : old_v[8*i+:8];
  endfunction
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: byte-lane writable word RAM, synchronous write, asynchronous read, no reset.
module dmem_ram #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  input  logic [3:0]        we,
  output logic [31:0]       rdata
);
  logic [31:0] mem_q [2**ADDR_W];
  always_ff @(posedge clk)
    for (int i = 0; i < 4; i++)
      if (we[i]) mem_q[addr][8*i+:8] <= wdata[8*i+:8];
  assign rdata = mem_q[addr];
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: same-cycle data RAM plus MMIO window (LED, CYCLE, STORES, STATUS).
// MMIO registers exist only when DMEM_MMIO_EN is defined; otherwise MMIO addresses are out of range.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] MMIO_BASE = MMIO_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] daddr,
  input  logic [31:0] dwdata,
  input  logic [3:0]  dwe,
  output logic [31:0] drdata,
  output logic [31:0] led_out,
  output logic        err
);
`ifdef DMEM_MMIO_EN
  localparam bit MMIO_ON = 1'b1;
`else
  localparam bit MMIO_ON = 1'b0;
`endif
  kind_e       kind;
  logic [31:0] ram_rdata, mmio_rdata;
  logic [3:0]  ram_we;
  logic        clr, err_q, err_d;
  logic        unused;
  assign unused = ^daddr[1:0];
  always_comb begin
    kind = daddr[31:ADDR_W+2] == '0 ? K_RAM :
           (MMIO_ON && daddr[31:8] == MMIO_BASE[31:8]) ? K_MMIO : K_OOR;
    ram_we = (kind == K_RAM && !reset) ? dwe : 4'b0;
    drdata = kind == K_RAM ? ram_rdata : kind == K_MMIO ? mmio_rdata : '0;
    err_d = kind == K_OOR || (err_q && !clr);
  end
  dmem_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk  (clk),
    .addr (daddr[ADDR_W+1:2]),
    .wdata(dwdata),
    .we   (ram_we),
    .rdata(ram_rdata)
  );
  always_ff @(posedge clk or posedge reset)
    if (reset) err_q <= 1'b0;
    else err_q <= err_d;
  assign err = err_q;
`ifdef DMEM_MMIO_EN
  logic [31:0] led_q, led_d, cyc_q, st_q, st_d;
  logic [7:0]  off;
  assign off = {daddr[7:2], 2'b00};
  always_comb begin
    led_d = (kind == K_MMIO && off == OFF_LED) ? lane_merge(led_q, dwdata, dwe) : led_q;
    st_d = st_q + {31'b0, kind == K_RAM && dwe != 4'b0};
    clr = kind == K_MMIO && off == OFF_STATUS && dwe[0] && dwdata[0];
    mmio_rdata = off == OFF_LED ? led_q : off == OFF_CYCLE ? cyc_q :
                 off == OFF_STORES ? st_q : off == OFF_STATUS ? {31'b0, err_q} : '0;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      led_q <= '0;
      cyc_q <= '0;
      st_q  <= '0;
    end else begin
      led_q <= led_d;
      cyc_q <= cyc_q + 32'd1;
      st_q  <= st_d;
    end
  assign led_out = led_q;
`else
  assign clr = 1'b0;
  assign mmio_rdata = '0;
  assign led_out = '0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed plan steps plus random traffic against a byte-addressed reference model.
module tb_dmem_responder;
`ifdef DMEM_MMIO_EN
  localparam bit M = 1'b1;
`else
  localparam bit M = 1'b0;
`endif
  logic        clk = 1'b0;
  logic        reset, err;
  logic [31:0] daddr, dwdata, drdata, led_out;
  logic [3:0]  dwe;
  int vectors = 0, miscompares = 0;
  logic [7:0]  mb [4096];
  bit          mv [4096];
  logic [31:0] m_led, m_cyc, m_st;
  logic        m_err;

  dmem_responder dut (
    .clk(clk), .reset(reset), .daddr(daddr), .dwdata(dwdata), .dwe(dwe),
    .drdata(drdata), .led_out(led_out), .err(err)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int kind_of(input logic [31:0] a);
    if (a < 32'd4096) return 0;
    if (M && a[31:8] == 24'hFFFFFF) return 1;
    return 2;
  endfunction

  function automatic void model_reset();
    m_led = 0; m_cyc = 0; m_st = 0; m_err = 0;
  endfunction

  function automatic bit model_read(input logic [31:0] a, output logic [31:0] v);
    int k = kind_of(a);
    int b = int'(a & 32'hFFC);
    bit ok = 1'b1;
    v = 0;
    if (k == 0)
      for (int i = 0; i < 4; i++) begin v[8*i+:8] = mb[b+i]; ok &= mv[b+i]; end
    else if (k == 1)
      case (a[7:2])
        6'd0: v = m_led;
        6'd1: v = m_cyc;
        6'd2: v = m_st;
        6'd3: v = {31'b0, m_err};
        default: v = 0;
      endcase
    return ok;
  endfunction

  function automatic void model_edge(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we);
    int k = kind_of(a);
    int b = int'(a & 32'hFFC);
    if (k == 0) for (int i = 0; i < 4; i++) if (we[i]) begin mb[b+i] = wd[8*i+:8]; mv[b+i] = 1'b1; end
    if (k == 0 && we != 0) m_st++;
    if (k == 1 && a[7:2] == 0) for (int i = 0; i < 4; i++) if (we[i]) m_led[8*i+:8] = wd[8*i+:8];
    m_err = (k == 2) || (m_err && !(k == 1 && a[7:2] == 3 && we[0] && wd[0]));
    m_cyc++;
  endfunction

  task automatic check_now(input string tag);
    logic [31:0] v;
    #1;
    if (model_read(daddr, v)) chk({tag, ".rd"}, drdata, v);
    chk({tag, ".led"}, led_out, m_led);
    chk({tag, ".err"}, {31'b0, err}, {31'b0, m_err});
    if (!reset) model_edge(daddr, dwdata, dwe);
  endtask

  task automatic step(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] we, input string tag);
    @(negedge clk);
    daddr = a; dwdata = wd; dwe = we;
    check_now(tag);
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] edges [4] = '{32'h0000_0FFC, 32'h0000_1000, 32'hFFFF_FEFC, 32'hFFFF_FF3C};
    reset = 1'b1; daddr = 32'hFFFF_FF04; dwdata = 0; dwe = 0;
    model_reset();
    repeat (2) @(negedge clk);
    check_now("in_reset");
    @(negedge clk);
    reset = 1'b0;
    check_now("cyc0");
    step(32'hFFFF_FF04, 0, 4'h0, "cyc1");
    step(32'hFFFF_FF04, 0, 4'h0, "cyc2");
    step(32'h0000_0000, 32'h1111_1111, 4'hF, "init0");
    step(32'h0000_0010, 32'hDEAD_BEEF, 4'hF, "w10a");
    step(32'h0000_0010, 32'h0000_0055, 4'h1, "w10b");
    step(32'h0000_0010, 0, 4'h0, "r10");
    chk("plan_merge", drdata, 32'hDEAD_BE55);
    step(32'hFFFF_FF08, 0, 4'h0, "stores");
    step(32'h0000_0020, 0, 4'hF, "z20");
    step(32'h0000_0020, 32'h1234_5678, 4'hF, "rw20");
    chk("plan_old20", drdata, 32'h0);
    step(32'h0000_0020, 0, 4'h0, "r20");
    chk("plan_new20", drdata, 32'h1234_5678);
    step(32'h0001_0000, 32'hCAFE_F00D, 4'hF, "oorw");
    step(32'hFFFF_FF0C, 0, 4'h0, "status");
    chk("plan_err", {31'b0, err}, 32'h1);
    step(32'h0000_0000, 0, 4'h0, "r0_kept");
    chk("plan_r0", drdata, 32'h1111_1111);
    step(32'h8000_0000, 0, 4'h0, "oorr");
    step(32'hFFFF_FF0C, 32'h1, 4'h1, "clr");
    step(32'h0000_0010, 0, 4'h0, "after_clr");
    step(32'hFFFF_FF00, 32'h0000_00A5, 4'hF, "led");
    step(32'h0000_0010, 0, 4'h0, "led_chk");
    @(negedge clk);
    #2;
    reset = 1'b1; daddr = 32'h0000_0010; dwdata = 32'hFFFF_FFFF; dwe = 4'hF;
    #1;
    model_reset();
    chk("arst_led", led_out, 32'h0);
    chk("arst_err", {31'b0, err}, 32'h0);
    @(negedge clk);
    reset = 1'b0; dwe = 4'h0;
    check_now("keep10");
    chk("plan_keep", drdata, 32'hDEAD_BE55);
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 3))
        0: a = $urandom_range(0, 255);
        1: a = 32'hFFFF_FF00 | $urandom_range(0, 255);
        2: a = $urandom;
        default: a = edges[$urandom_range(0, 3)];
      endcase
      step(a, $urandom, ($urandom_range(0, 1) != 0) ? 4'($urandom) : 4'h0, "rnd");
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
